aes_inv_key_schedule: RTL and testbench



---
 rtl/aes_inv_key_schedule.sv | 113 +++++++++++
 tb/tb_aes_inv_key_schedule.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: walks round keys from round 10 down to round 0,
// one round per enabled cycle, so the decryptor never stores the full expansion.
module aes_inv_key_schedule #(
  parameter int unsigned word_size  = 8,
  parameter int unsigned array_size = 16,
  parameter int unsigned num_rounds = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic                              enable,
  input  logic [word_size*array_size-1:0]   key_in,
  output logic [word_size*array_size-1:0]   round_key,
  output logic [3:0]                        round_num,
  output logic                              key_valid,
  output logic                              done
);

  localparam int unsigned KeyW = word_size * array_size;

  // Forward AES S-box, entry 0 in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // Entry x sits at bit offset (255 - x) * 8 = {~x, 3'b000}.
    return SboxTable[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [7:0]      rcon;
  logic [31:0]     a0, a1, a2, a3;
  logic [31:0]     b0, b1, b2, b3;
  logic [31:0]     rot, sub;
  logic [KeyW-1:0] prev_key;

  always_comb begin
    case (round_num)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    a0 = round_key[127:96];
    a1 = round_key[95:64];
    a2 = round_key[63:32];
    a3 = round_key[31:0];
    b3 = a3 ^ a2;
    b2 = a2 ^ a1;
    b1 = a1 ^ a0;
    rot = {b3[23:0], b3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    b0 = a0 ^ sub ^ {rcon, 24'h0};
    prev_key = {b0, b1, b2, b3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      round_key <= '0;
      round_num <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StRun, StDone: begin
          if (load) begin
            state_q   <= StRun;
            round_key <= key_in;
            round_num <= 4'(num_rounds);
            key_valid <= 1'b1;
            done      <= 1'b0;
          end else if (state_q == StRun && enable) begin
            round_key <= prev_key;
            round_num <= round_num - 4'd1;
            if (round_num == 4'd1) begin
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          round_key <= '0;
          round_num <= '0;
          key_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: GF(2^8)-derived reference model checked every
// cycle, plus FIPS-197 literal round keys for the directed scenarios.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst, load, enable;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid, done;

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .enable    (enable),
    .key_in    (key_in),
    .round_key (round_key),
    .round_num (round_num),
    .key_valid (key_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gmul(inv, v);  // v^254 = v^-1, 0 -> 0
    s = 8'h63;
    for (int k = 0; k < 5; k++) s ^= (inv << k) | (inv >> (8 - k));
    return s;
  endfunction

  function automatic logic [7:0] rcon_ref(input int r);
    logic [7:0] c = 8'h01;
    for (int i = 1; i < r; i++) c = gmul(c, 8'h02);
    return c;
  endfunction

  function automatic logic [127:0] prev_ref(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] b [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    b[3] = w[3] ^ w[2];
    b[2] = w[2] ^ w[1];
    b[1] = w[1] ^ w[0];
    t = {b[3][23:0], b[3][31:24]};
    for (int j = 0; j < 4; j++) t[31 - 8*j -: 8] = sbox_ref(t[31 - 8*j -: 8]);
    b[0] = w[0] ^ t ^ {rcon_ref(r), 24'h0};
    return {b[0], b[1], b[2], b[3]};
  endfunction

  logic [127:0] m_keys [0:10];
  logic [127:0] m_key   = '0;
  int           m_num   = 0;
  bit           m_valid = 1'b0;
  bit           m_done  = 1'b0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_key = '0; m_num = 0; m_valid = 1'b0; m_done = 1'b0;
    end else if (load) begin
      m_keys[10] = key_in;
      for (int r = 10; r >= 1; r--) m_keys[r-1] = prev_ref(m_keys[r], r);
      m_key = key_in; m_num = 10; m_valid = 1'b1; m_done = 1'b0;
    end else if (m_valid && !m_done && enable) begin
      m_num--;
      m_key  = m_keys[m_num];
      m_done = (m_num == 0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model round_key", round_key, m_key);
      chk("model round_num", 128'(round_num), 128'(m_num));
      chk("model key_valid", 128'(key_valid), 128'(m_valid));
      chk("model done", 128'(done), 128'(m_done));
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] KeyA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KeyA9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] KeyA1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KeyA0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyC10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KeyC0  = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic [127:0] k, input int n,
                         input logic v, input logic d);
    look();
    chk({name, " key"}, round_key, k);
    chk({name, " num"}, 128'(round_num), 128'(n));
    chk({name, " valid"}, 128'(key_valid), 128'(v));
    chk({name, " done"}, 128'(done), 128'(d));
  endtask

  logic [127:0] new_key;

  initial begin
    rst = 1'b1; load = 1'b1; enable = 1'b0; key_in = KeyA10;
    tick(); tick();
    chk_out("reset", '0, 0, 1'b0, 1'b0);
    rst = 1'b0; load = 1'b0; enable = 1'b1;
    tick(); tick(); tick();
    chk_out("idle enable", '0, 0, 1'b0, 1'b0);

    // FIPS-197 Appendix A
    load = 1'b1; key_in = KeyA10; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1;
    chk_out("A r10", KeyA10, 10, 1'b1, 1'b0);
    tick();
    chk_out("A r9", KeyA9, 9, 1'b1, 1'b0);
    repeat (8) tick();
    chk_out("A r1", KeyA1, 1, 1'b1, 1'b0);
    tick();
    chk_out("A r0", KeyA0, 0, 1'b1, 1'b1);

    // FIPS-197 C.1, enable held through load
    load = 1'b1; key_in = KeyC10; enable = 1'b1;
    tick();
    load = 1'b0;
    chk_out("C r10", KeyC10, 10, 1'b1, 1'b0);
    repeat (10) tick();
    chk_out("C r0", KeyC0, 0, 1'b1, 1'b1);
    repeat (3) tick();
    chk_out("C hold", KeyC0, 0, 1'b1, 1'b1);

    // Stall: enable 1,0,0,1 after load
    load = 1'b1; key_in = KeyA10; enable = 1'b0;
    tick();
    load = 1'b0;
    chk_out("stall r10", KeyA10, 10, 1'b1, 1'b0);
    enable = 1'b1; tick();
    chk_out("stall r9", KeyA9, 9, 1'b1, 1'b0);
    enable = 1'b0; tick(); tick();
    chk_out("stall hold", KeyA9, 9, 1'b1, 1'b0);
    enable = 1'b1; tick();
    look();
    chk("stall r8 num", 128'(round_num), 128'(8));

    // Restart at round 5
    load = 1'b1; key_in = KeyA10;
    tick();
    load = 1'b0;
    repeat (5) tick();
    look();
    chk("restart at 5 num", 128'(round_num), 128'(5));
    new_key = {$urandom, $urandom, $urandom, $urandom};
    load = 1'b1; key_in = new_key;
    tick();
    load = 1'b0;
    chk_out("restart", new_key, 10, 1'b1, 1'b0);

    // Abort at round 3 with a simultaneous load
    repeat (7) tick();
    look();
    chk("abort at 3 num", 128'(round_num), 128'(3));
    rst = 1'b1; load = 1'b1; key_in = KeyC10;
    tick();
    rst = 1'b0; load = 1'b0;
    chk_out("abort", '0, 0, 1'b0, 1'b0);
    tick();
    chk_out("after abort", '0, 0, 1'b0, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(99) == 0);
      load   = ($urandom_range(15) == 0);
      enable = ($urandom_range(3) != 0);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0; load = 1'b0; enable = 1'b0;
    tick();
    look();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
